case_4_mul_share_arb: RTL and testbench

//  Round-robin arbiter sharing one 9b-unsigned x 8b-signed -> 10b multiplier among NUM_REQ requesters.

---
 rtl/case_4_mul_pkg.sv | 25 ++
 rtl/case_4_mul_rr_pick.sv | 32 +++
 rtl/case_4_mul_share_arb.sv | 150 +++++++++++++++
 tb/tb_case_4_mul_share_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/case_4_mul_pkg.sv
// Shared widths, ID-width helper and response record for the round-robin shared multiplier.
package case_4_mul_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DIN0_W_DEF  = 9;
  localparam int DIN1_W_DEF  = 8;
  localparam int DOUT_W_DEF  = 10;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_w(NUM_REQ_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [DOUT_W_DEF-1:0] data;
  } rsp_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/case_4_mul_rr_pick.sv
// Rotate-priority picker: the search starts one past ptr and the first asserted request wins.
module case_4_mul_rr_pick
  import case_4_mul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/case_4_mul_share_arb.sv
// Round-robin arbiter in front of one shared 9b-unsigned x 8b-signed multiplier, tagging results with requester ID.
// Define MUL_OUT_REG_EN to add a register stage after the product (latency 2 instead of 1).
//
// Output stage states:
//   state     | meaning
//   OUT_EMPTY | no result held, rsp_valid = 0
//   OUT_FULL  | result held on rsp_id/rsp_data, rsp_valid = 1
module case_4_mul_share_arb
  import case_4_mul_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DIN0_W  = DIN0_W_DEF,
  parameter  int DIN1_W  = DIN1_W_DEF,
  parameter  int DOUT_W  = DOUT_W_DEF,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0] req_a,
  input  logic [NUM_REQ*DIN1_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DOUT_W-1:0]         rsp_data,
  output logic [CNT_W-1:0]          ops_done
);

  localparam int              PROD_W  = DIN0_W + 1 + DIN1_W;
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]          ptr;
  logic [ID_W-1:0]          pick_idx;
  logic [NUM_REQ-1:0]       grant;
  logic                     pick_found;
  logic                     advance;
  logic                     accept;
  logic                     out_free;
  logic [DIN0_W-1:0]        a_sel;
  logic [DIN1_W-1:0]        b_sel;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic [DOUT_W-1:0]        prod;
  logic                     stage_valid;
  logic [ID_W-1:0]          stage_id;
  logic [DOUT_W-1:0]        stage_data;
  out_state_t               state;

  case_4_mul_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .idx       (pick_idx),
    .found     (pick_found)
  );

  assign a_sel = req_a[pick_idx*DIN0_W +: DIN0_W];
  assign b_sel = req_b[pick_idx*DIN1_W +: DIN1_W];

  // A is zero-extended, B sign-extended; only the low DOUT_W product bits are kept.
  assign a_ext = {{(PROD_W-DIN0_W){1'b0}}, a_sel};
  assign b_ext = {{(PROD_W-DIN1_W){b_sel[DIN1_W-1]}}, b_sel};
  assign prod  = DOUT_W'(a_ext * b_ext);

  assign rsp_valid = (state == OUT_FULL);
  assign out_free  = !rsp_valid || rsp_ready;
  assign req_ready = grant & {NUM_REQ{advance}};
  assign accept    = pick_found && advance;

`ifdef MUL_OUT_REG_EN
  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic [DOUT_W-1:0] s1_data;

  // Stage 1 may refill whenever it is empty or its content moves on to the output.
  assign advance = !s1_valid || out_free;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_data  <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_id   <= pick_idx;
        s1_data <= prod;
      end
    end
  end

  assign stage_valid = s1_valid;
  assign stage_id    = s1_id;
  assign stage_data  = s1_data;
`else
  assign advance     = out_free;
  assign stage_valid = accept;
  assign stage_id    = pick_idx;
  assign stage_data  = prod;
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= OUT_EMPTY;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (stage_valid) begin
            state    <= OUT_FULL;
            rsp_id   <= stage_id;
            rsp_data <= stage_data;
          end
        end
        OUT_FULL: begin
          if (rsp_ready && stage_valid) begin
            rsp_id   <= stage_id;
            rsp_data <= stage_data;
          end else if (rsp_ready) begin
            state <= OUT_EMPTY;
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr <= PTR_RST;
    end else if (accept) begin
      ptr <= pick_idx;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ops_done <= '0;
    end else if (rsp_valid && rsp_ready) begin
      ops_done <= ops_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_case_4_mul_share_arb.sv
// Self-checking bench for case_4_mul_share_arb: directed steps plus random traffic against a queue-level model.
module tb_case_4_mul_share_arb;
  import case_4_mul_pkg::*;

`ifdef MUL_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        ap_clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [35:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_data;
  logic [15:0] ops_done;

  case_4_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .ops_done  (ops_done)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;

  // requester side: pending flag and held operands
  bit         pv[4];
  logic [8:0] pa[4];
  logic [7:0] pb[4];

  // reference model: rotation pointer, result slots (slot LAT-1 is the visible output), op count
  int   m_ptr;
  bit   mv[2];
  rsp_t ms[2];
  int   m_ops;
  int   dq[$];

  function automatic logic [9:0] exp_prod(input logic [8:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'($signed(b));
    return p[9:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = pv[i];
      req_a[i*9 +: 9]    = pa[i];
      req_b[i*8 +: 8]    = pb[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 3;
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    m_ops = 0;
  endtask

  task automatic refill(input bit all);
    for (int i = 0; i < 4; i++) begin
      if (!pv[i] && (all || ($urandom_range(0, 1) == 1))) begin
        pv[i] = 1'b1;
        pa[i] = 9'($urandom);
        pb[i] = 8'($urandom);
      end
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model, return at rising edge + 1.
  task automatic cycle(input bit rdy);
    int         g;
    bit         adv;
    bit         out_v;
    logic [3:0] er;
    rsp_ready = rdy;
    drive();
    @(negedge ap_clk);
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      if (g < 0 && pv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    out_v = mv[LAT-1];
    if (LAT == 1) adv = !out_v || rdy;
    else          adv = !mv[0] || !out_v || rdy;
    er = (g >= 0 && adv) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(out_v));
    if (out_v) begin
      chk("rsp_id", 32'(rsp_id), 32'(ms[LAT-1].id));
      chk("rsp_data", 32'(rsp_data), 32'(ms[LAT-1].data));
    end
    chk("ops_done", 32'(ops_done), m_ops);
    for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) dq.push_back(i);
    if (out_v && rdy) m_ops = (m_ops + 1) & 32'hFFFF;
    if (LAT == 2) begin
      if (!out_v || rdy) begin
        mv[1] = mv[0];
        ms[1] = ms[0];
      end
      if (adv) mv[0] = 1'b0;
    end else if (adv) begin
      mv[0] = 1'b0;
    end
    if (g >= 0 && adv) begin
      mv[0]      = 1'b1;
      ms[0].id   = 2'(g);
      ms[0].data = exp_prod(pa[g], pb[g]);
      m_ptr      = g;
      pv[g]      = 1'b0;
    end
    @(posedge ap_clk);
    #1;
  endtask

  // Called at rising edge + 1; reset is held and released before the next falling edge.
  task automatic do_reset();
    ap_rst = 1'b1;
    #2;
    ap_rst = 1'b0;
    model_reset();
    dq.delete();
  endtask

  initial begin
    ap_rst    = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
      pb[i] = '0;
    end
    drive();
    model_reset();
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    cycle(1'b1);

    // single request, then truncation and sign cases
    pv[0] = 1'b1; pa[0] = 9'd100; pb[0] = 8'd5;
    cycle(1'b1);
    repeat (LAT-1) cycle(1'b1);
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_data", 32'(rsp_data), 32'h1F4);
    cycle(1'b1);
    chk("t1_ops", 32'(ops_done), 1);

    pv[0] = 1'b1; pa[0] = 9'd511; pb[0] = 8'h80;
    cycle(1'b1);
    repeat (LAT-1) cycle(1'b1);
    chk("t2_data_min", 32'(rsp_data), 32'h080);
    pv[0] = 1'b1; pa[0] = 9'd3; pb[0] = 8'hFE;
    cycle(1'b1);
    repeat (LAT-1) cycle(1'b1);
    chk("t2_data_neg", 32'(rsp_data), 32'h3FA);
    cycle(1'b1);
    cycle(1'b1);

    // all requesters busy: strict rotation from requester 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      refill(1'b1);
      cycle(1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", (dq.size() > i) ? dq[i] : 99, i % 4);
    end

    // consumer stall with a full output
    for (int i = 0; i < 5; i++) begin
      refill(1'b1);
      cycle(1'b0);
    end
    chk("t4_ready_held", 32'(req_ready), 0);
    chk("t4_valid_held", 32'(rsp_valid), 1);
    refill(1'b1);
    dq.delete();
    cycle(1'b1);
    chk("t4_accept_on_release", dq.size(), 1);

    // random traffic, then asynchronous reset between clock edges
    for (int i = 0; i < 300; i++) begin
      refill(1'b0);
      cycle($urandom_range(0, 3) != 0);
    end
    refill(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("t5_valid_drop", 32'(rsp_valid), 0);
    chk("t5_ops_clear", 32'(ops_done), 0);
    chk("t5_data_clear", 32'(rsp_data), 0);
    ap_rst = 1'b0;
    model_reset();
    dq.delete();
    refill(1'b1);
    cycle(1'b1);
    chk("t5_first_grant", (dq.size() > 0) ? dq[0] : 99, 0);
    for (int i = 0; i < 40; i++) begin
      refill(1'b0);
      cycle($urandom_range(0, 1) == 1);
    end

    // counter wrap: 65537 completed handshakes
    do_reset();
    for (int i = 0; i < 65537 + LAT; i++) begin
      refill(1'b1);
      cycle(1'b1);
    end
    chk("t6_ops_wrap", 32'(ops_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
